// File: rtl/ipa_ls_responder.sv
// ipa_ls_responder: memory-side responder for the IPA CGRA load/store ports.
// Arbitrates TCDM-style requests from NB_LS ports round-robin onto one
// single-ported word memory and returns a registered response one cycle after grant.
//
// Optional feature macro: IPA_LS_STALL_EN. When it is defined, a 16-bit LFSR
// suppresses grants pseudo-randomly to exercise grant-wait paths.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   ls_req_i          per-port request
//   ls_add_i          per-port byte address
//   ls_wen_i          per-port 1 = read, 0 = write
//   ls_wdata_i        per-port write data
//   ls_be_i           per-port byte enables (writes only)
//   ls_gnt_o          grant, one-hot or zero (combinational)
//   ls_r_valid_o      response valid, one cycle after grant
//   ls_r_rdata_o      response data, zero on non-valid ports
//   err_o             sticky out-of-range flag
//   err_addr_o        address of first out-of-range access
//   access_cnt_o      number of granted accesses (wraps)
module ipa_ls_responder #(
  parameter int unsigned           NB_LS      = 16,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           MEM_WORDS  = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h1000_0000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NB_LS-1:0]              ls_req_i,
  input  logic [NB_LS*ADDR_WIDTH-1:0]   ls_add_i,
  input  logic [NB_LS-1:0]              ls_wen_i,
  input  logic [NB_LS*DATA_WIDTH-1:0]   ls_wdata_i,
  input  logic [NB_LS*DATA_WIDTH/8-1:0] ls_be_i,
  output logic [NB_LS-1:0]              ls_gnt_o,
  output logic [NB_LS-1:0]              ls_r_valid_o,
  output logic [NB_LS*DATA_WIDTH-1:0]   ls_r_rdata_o,
  output logic                          err_o,
  output logic [ADDR_WIDTH-1:0]         err_addr_o,
  output logic [31:0]                   access_cnt_o
);

  localparam int unsigned BeW  = DATA_WIDTH / 8;
  localparam int unsigned PtrW = (NB_LS > 1) ? $clog2(NB_LS) : 1;
  localparam int unsigned IdxW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [ADDR_WIDTH-1:0] MemBytes = ADDR_WIDTH'(4 * MEM_WORDS);

  logic [PtrW-1:0]       ptr_q, ptr_d;
  logic                  found;
  logic [PtrW-1:0]       sel;
  logic                  stall;
  logic                  grant;
  logic [ADDR_WIDTH-1:0] sel_add, sel_off;
  logic                  sel_wen;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic [BeW-1:0]        sel_be;
  logic                  in_range;
  logic [IdxW-1:0]       word_idx;
  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];
  logic [NB_LS-1:0]      rvalid_q;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q;
  logic [ADDR_WIDTH-1:0] err_addr_q;
  logic [31:0]           cnt_q;

`ifdef IPA_LS_STALL_EN
  // Fibonacci LFSR, taps 16/14/13/11, shifting towards bit 0.
  logic [15:0] lfsr_q;
  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= 16'hACE1;
    else     lfsr_q <= {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
  end
  assign stall = lfsr_q[0];
`else
  assign stall = 1'b0;
`endif

  // Round-robin search starting at ptr_q, wrapping modulo NB_LS.
  always_comb begin
    int unsigned j;
    found = 1'b0;
    sel   = '0;
    j     = 0;
    for (int unsigned i = 0; i < NB_LS; i++) begin
      j = (32'(ptr_q) + i) % NB_LS;
      if (!found && ls_req_i[j]) begin
        found = 1'b1;
        sel   = PtrW'(j);
      end
    end
  end

  assign grant    = found && !stall && !rst;
  assign ls_gnt_o = grant ? (NB_LS'(1) << sel) : '0;
  assign ptr_d    = (sel == PtrW'(NB_LS - 1)) ? '0 : sel + 1'b1;

  // Payload of the selected port.
  assign sel_add   = ls_add_i[sel*ADDR_WIDTH +: ADDR_WIDTH];
  assign sel_wen   = ls_wen_i[sel];
  assign sel_wdata = ls_wdata_i[sel*DATA_WIDTH +: DATA_WIDTH];
  assign sel_be    = ls_be_i[sel*BeW +: BeW];

  // Addresses below BASE_ADDR wrap to a huge offset and fail the bound check.
  assign sel_off  = sel_add - BASE_ADDR;
  assign in_range = sel_off < MemBytes;
  assign word_idx = sel_off[2 +: IdxW];

  always_comb begin
    rdata_d = '0;
    if (sel_wen) begin
      if (in_range) rdata_d = mem[word_idx];
      else          rdata_d = DATA_WIDTH'(32'hDEAD_BEEF);
    end
  end

  // Memory is not reset; grant is already suppressed while rst is high.
  always_ff @(posedge clk) begin
    if (grant && !sel_wen && in_range) begin
      for (int unsigned b = 0; b < BeW; b++) begin
        if (sel_be[b]) mem[word_idx][8*b +: 8] <= sel_wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q      <= '0;
      rvalid_q   <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
      cnt_q      <= '0;
    end else begin
      rvalid_q <= ls_gnt_o;
      rdata_q  <= grant ? rdata_d : '0;
      if (grant) begin
        ptr_q <= ptr_d;
        cnt_q <= cnt_q + 32'd1;
        if (!in_range) begin
          err_q <= 1'b1;
          if (!err_q) err_addr_q <= sel_add;
        end
      end
    end
  end

  // Masking with rst drops a response still pending when reset rises.
  assign ls_r_valid_o = rst ? '0 : rvalid_q;

  always_comb begin
    ls_r_rdata_o = '0;
    for (int unsigned k = 0; k < NB_LS; k++) begin
      if (rvalid_q[k] && !rst) ls_r_rdata_o[k*DATA_WIDTH +: DATA_WIDTH] = rdata_q;
    end
  end

  assign err_o        = err_q;
  assign err_addr_o   = err_addr_q;
  assign access_cnt_o = cnt_q;

endmodule

// File: tb/tb_ipa_ls_responder.sv
// Testbench for ipa_ls_responder: directed scenarios plus randomized traffic
// checked against a transaction-level reference model.
module tb_ipa_ls_responder;

  localparam int          NB   = 16;
  localparam int          DW   = 32;
  localparam int          AW   = 32;
  localparam int          MW   = 1024;
  localparam logic [31:0] BASE = 32'h1000_0000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NB-1:0]          req, wen;
  logic [NB-1:0][AW-1:0]  add;
  logic [NB-1:0][DW-1:0]  wdata;
  logic [NB-1:0][3:0]     be;
  logic [NB-1:0]          gnt, rvalid;
  logic [NB-1:0][DW-1:0]  rdata;
  logic                   err;
  logic [AW-1:0]          err_addr;
  logic [31:0]            cnt;

  int errors = 0;
  int checks = 0;

  ipa_ls_responder #(
    .NB_LS(NB), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_WORDS(MW), .BASE_ADDR(BASE)
  ) dut (
    .clk(clk), .rst(rst),
    .ls_req_i(req), .ls_add_i(add), .ls_wen_i(wen), .ls_wdata_i(wdata), .ls_be_i(be),
    .ls_gnt_o(gnt), .ls_r_valid_o(rvalid), .ls_r_rdata_o(rdata),
    .err_o(err), .err_addr_o(err_addr), .access_cnt_o(cnt)
  );

  // Reference model state
  int          m_ptr;
  logic [31:0] m_cnt;
  bit          m_err;
  logic [31:0] m_err_addr;
  logic [31:0] m_mem [int];
  bit          p_valid, p_known;
  int          p_port;
  logic [31:0] p_data;

  function automatic void model_reset();
    m_ptr = 0; m_cnt = 0; m_err = 0; m_err_addr = 0;
    p_valid = 0; p_known = 0; p_port = 0; p_data = 0;
    m_mem.delete();
  endfunction

  function automatic int model_pick();
    for (int i = 0; i < NB; i++) begin
      int k;
      k = (m_ptr + i) % NB;
      if (req[k]) return k;
    end
    return -1;
  endfunction

  function automatic void model_grant(int k);
    logic [31:0] off, w;
    int          idx;
    off = add[k] - BASE;
    idx = int'(off >> 2);
    m_cnt = m_cnt + 1;
    m_ptr = (k + 1) % NB;
    p_valid = 1; p_port = k; p_known = 1; p_data = 0;
    if (off < 32'(4 * MW)) begin
      if (wen[k]) begin
        if (m_mem.exists(idx)) p_data = m_mem[idx];
        else p_known = 0;
      end else if (m_mem.exists(idx) || be[k] == 4'hF) begin
        w = m_mem.exists(idx) ? m_mem[idx] : 32'h0;
        for (int b = 0; b < 4; b++) if (be[k][b]) w[8*b +: 8] = wdata[k][8*b +: 8];
        m_mem[idx] = w;
      end
    end else begin
      p_data = wen[k] ? 32'hDEAD_BEEF : 32'h0;
      if (!m_err) m_err_addr = add[k];
      m_err = 1;
    end
  endfunction

  task automatic clear_inputs();
    req = '0; wen = '1;
    for (int i = 0; i < NB; i++) begin
      add[i] = '0; wdata[i] = '0; be[i] = '0;
    end
  endtask

  // Leaves the bench one step after a rising edge with rst low.
  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    req = '1;
    @(negedge clk);
    checks++; if (gnt !== 16'h0) begin errors++; $display("FAIL reset_gnt: got %h want 0", gnt); end
    repeat (2) @(posedge clk);
    #1;
    checks++; if (rvalid !== 16'h0) begin errors++; $display("FAIL reset_rvalid: got %h want 0", rvalid); end
    checks++; if (rdata !== '0) begin errors++; $display("FAIL reset_rdata: got %h want 0", rdata); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
    checks++; if (err_addr !== 32'h0) begin errors++; $display("FAIL reset_err_addr: got %h want 0", err_addr); end
    checks++; if (cnt !== 32'h0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", cnt); end
    rst = 1'b0;
    req = '0;
    model_reset();
  endtask

  task automatic test_write_read();
    do_reset();
    req[3] = 1'b1; add[3] = BASE + 32'h10; wen[3] = 1'b0; wdata[3] = 32'h1234_5678; be[3] = 4'hF;
    @(negedge clk);
    checks++; if (gnt !== 16'h0008) begin errors++; $display("FAIL wr_gnt: got %h want 0008", gnt); end
    @(posedge clk); #1;
    checks++; if (rvalid !== 16'h0008) begin errors++; $display("FAIL wr_rvalid: got %h want 0008", rvalid); end
    checks++; if (rdata[3] !== 32'h0) begin errors++; $display("FAIL wr_rdata: got %h want 0", rdata[3]); end
    wen[3] = 1'b1;
    @(negedge clk);
    checks++; if (gnt !== 16'h0008) begin errors++; $display("FAIL rd_gnt: got %h want 0008", gnt); end
    @(posedge clk); #1;
    checks++; if (rvalid !== 16'h0008) begin errors++; $display("FAIL rd_rvalid: got %h want 0008", rvalid); end
    checks++; if (rdata[3] !== 32'h1234_5678) begin errors++; $display("FAIL rd_rdata: got %h want 12345678", rdata[3]); end
    checks++; if (cnt !== 32'd2) begin errors++; $display("FAIL wr_rd_cnt: got %0d want 2", cnt); end
    req = '0;
    @(posedge clk); #1;
    checks++; if (rvalid !== 16'h0) begin errors++; $display("FAIL rvalid_pulse: got %h want 0", rvalid); end
  endtask

  task automatic test_byte_enable();
    req[7] = 1'b1; add[7] = BASE + 32'h40; wen[7] = 1'b0; wdata[7] = 32'hAABB_CCDD; be[7] = 4'hF;
    @(posedge clk); #1;
    wdata[7] = 32'h1122_3344; be[7] = 4'b0101;
    @(posedge clk); #1;
    wen[7] = 1'b1;
    @(negedge clk);
    checks++; if (gnt !== 16'h0080) begin errors++; $display("FAIL be_gnt: got %h want 0080", gnt); end
    @(posedge clk); #1;
    checks++; if (rdata[7] !== 32'hAA22_CC44) begin errors++; $display("FAIL be_rdata: got %h want aa22cc44", rdata[7]); end
    req = '0;
    @(posedge clk); #1;
  endtask

  task automatic test_round_robin();
    do_reset();
    req = '1;
    for (int i = 0; i < NB; i++) add[i] = BASE + 32'(4 * i);
    for (int c = 0; c < 17; c++) begin
      @(negedge clk);
      checks++;
      if (gnt !== (16'h1 << (c % NB))) begin
        errors++; $display("FAIL rr_gnt[%0d]: got %h want %h", c, gnt, 16'h1 << (c % NB));
      end
      @(posedge clk); #1;
      checks++;
      if (rvalid !== (16'h1 << (c % NB))) begin
        errors++; $display("FAIL rr_rvalid[%0d]: got %h want %h", c, rvalid, 16'h1 << (c % NB));
      end
    end
    checks++; if (cnt !== 32'd17) begin errors++; $display("FAIL rr_cnt: got %0d want 17", cnt); end
    req = '0;
    @(posedge clk); #1;
  endtask

  task automatic test_out_of_range();
    do_reset();
    // Last in-range word must still be ordinary memory.
    req[5] = 1'b1; add[5] = BASE + 32'hFFC; wen[5] = 1'b0; wdata[5] = 32'h5A5A_0FF0; be[5] = 4'hF;
    @(posedge clk); #1;
    wen[5] = 1'b1;
    @(posedge clk); #1;
    checks++; if (rdata[5] !== 32'h5A5A_0FF0) begin errors++; $display("FAIL top_word: got %h want 5a5a0ff0", rdata[5]); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL top_word_err: got %b want 0", err); end
    add[5] = BASE + 32'h1000;
    @(negedge clk);
    checks++; if (gnt !== 16'h0020) begin errors++; $display("FAIL oor_gnt: got %h want 0020", gnt); end
    @(posedge clk); #1;
    checks++; if (rvalid !== 16'h0020) begin errors++; $display("FAIL oor_rvalid: got %h want 0020", rvalid); end
    checks++; if (rdata[5] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL oor_rdata: got %h want deadbeef", rdata[5]); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL oor_err: got %b want 1", err); end
    checks++; if (err_addr !== BASE + 32'h1000) begin errors++; $display("FAIL oor_err_addr: got %h want 10001000", err_addr); end
    add[5] = BASE - 32'h4; wen[5] = 1'b0;
    @(posedge clk); #1;
    checks++; if (rdata[5] !== 32'h0) begin errors++; $display("FAIL oor_wr_rdata: got %h want 0", rdata[5]); end
    checks++; if (err_addr !== BASE + 32'h1000) begin errors++; $display("FAIL oor_sticky: got %h want 10001000", err_addr); end
    req = '0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    do_reset();
    req[2] = 1'b1; add[2] = BASE + 32'h20; wen[2] = 1'b0; wdata[2] = 32'hCAFE_F00D; be[2] = 4'hF;
    @(posedge clk); #1;
    wen[2] = 1'b1;
    @(negedge clk);
    checks++; if (gnt !== 16'h0004) begin errors++; $display("FAIL mid_gnt: got %h want 0004", gnt); end
    @(posedge clk); #1;
    rst = 1'b1; req = '0;
    #1;
    checks++; if (rvalid !== 16'h0) begin errors++; $display("FAIL mid_drop: got %h want 0", rvalid); end
    checks++; if (rdata !== '0) begin errors++; $display("FAIL mid_rdata: got %h want 0", rdata); end
    @(posedge clk); #1;
    req[2] = 1'b1; wen[2] = 1'b0; wdata[2] = 32'h0BAD_0BAD;
    @(negedge clk);
    checks++; if (gnt !== 16'h0) begin errors++; $display("FAIL mid_rst_gnt: got %h want 0", gnt); end
    @(posedge clk); #1;
    rst = 1'b0;
    req = '1; wen = '1;
    @(negedge clk);
    checks++; if (gnt !== 16'h0001) begin errors++; $display("FAIL post_rst_gnt: got %h want 0001", gnt); end
    @(posedge clk); #1;
    req = '0; req[2] = 1'b1;
    @(posedge clk); #1;
    checks++; if (rdata[2] !== 32'hCAFE_F00D) begin errors++; $display("FAIL mid_no_write: got %h want cafef00d", rdata[2]); end
    req = '0;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    int k;
    logic [NB-1:0] exp_g, exp_v, mask;
    do_reset();
    for (int it = 0; it < 300; it++) begin
      exp_v = p_valid ? (16'h1 << p_port) : 16'h0;
      checks++; if (rvalid !== exp_v) begin errors++; $display("FAIL rnd_rvalid[%0d]: got %h want %h", it, rvalid, exp_v); end
      if (p_valid && p_known) begin
        checks++;
        if (rdata[p_port] !== p_data) begin
          errors++; $display("FAIL rnd_rdata[%0d]: port %0d got %h want %h", it, p_port, rdata[p_port], p_data);
        end
      end
      mask = ~exp_v;
      for (int i = 0; i < NB; i++) begin
        if (mask[i] && rdata[i] !== 32'h0) begin
          checks++; errors++; $display("FAIL rnd_idle_rdata[%0d]: port %0d got %h want 0", it, i, rdata[i]);
        end
      end
      checks++; if (cnt !== m_cnt) begin errors++; $display("FAIL rnd_cnt[%0d]: got %0d want %0d", it, cnt, m_cnt); end
      checks++; if (err !== m_err) begin errors++; $display("FAIL rnd_err[%0d]: got %b want %b", it, err, m_err); end
      checks++; if (err_addr !== m_err_addr) begin errors++; $display("FAIL rnd_err_addr[%0d]: got %h want %h", it, err_addr, m_err_addr); end
      p_valid = 0;
      for (int i = 0; i < NB; i++) begin
        int r;
        req[i]   = ($urandom_range(0, 3) == 0);
        wen[i]   = $urandom_range(0, 1) == 1;
        wdata[i] = $urandom;
        be[i]    = $urandom_range(0, 1) ? 4'hF : 4'($urandom_range(0, 15));
        r = $urandom_range(0, 19);
        if (r == 0)      add[i] = BASE + 32'h1000 + 32'(4 * $urandom_range(0, 15));
        else if (r == 1) add[i] = BASE - 32'(4 * $urandom_range(1, 4));
        else             add[i] = BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
      end
      @(negedge clk);
      k = model_pick();
      exp_g = (k >= 0) ? (16'h1 << k) : 16'h0;
      checks++; if (gnt !== exp_g) begin errors++; $display("FAIL rnd_gnt[%0d]: got %h want %h", it, gnt, exp_g); end
      if (k >= 0) model_grant(k);
      @(posedge clk); #1;
    end
    req = '0;
    @(posedge clk); #1;
  endtask

`ifdef IPA_LS_STALL_EN
  task automatic test_stall();
    logic [15:0]   lf;
    logic [NB-1:0] exp_g;
    int            n;
    do_reset();
    lf = 16'hACE1;
    n  = 0;
    req = '1;
    for (int i = 0; i < NB; i++) add[i] = BASE + 32'(4 * i);
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      exp_g = lf[0] ? 16'h0 : (16'h1 << m_ptr);
      checks++; if (gnt !== exp_g) begin errors++; $display("FAIL stall_gnt[%0d]: got %h want %h", c, gnt, exp_g); end
      if (!lf[0]) begin
        n++;
        m_ptr = (m_ptr + 1) % NB;
      end
      lf = {lf[0] ^ lf[2] ^ lf[3] ^ lf[5], lf[15:1]};
      @(posedge clk); #1;
    end
    checks++; if (cnt !== 32'(n)) begin errors++; $display("FAIL stall_cnt: got %0d want %0d", cnt, n); end
    req = '0;
  endtask
`endif

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
`ifdef IPA_LS_STALL_EN
    test_stall();
`else
    test_write_read();
    test_byte_enable();
    test_round_robin();
    test_out_of_range();
    test_reset_mid();
    test_random();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got running want finished");
    $fatal(1);
  end

endmodule
